north_line_arbiter: RTL and testbench
=====================================

NORTH_LINE_ARBITER -- requirements
Module: north_line_arbiter

Interface
REQ-001 Parameter W, default 10: width of the shared north pad line.
REQ-002 Parameter TURN_CYCLES, default 2: bus-idle gap between owners, range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: maximum tenure under contention, range 2..1023.
REQ-004 wb_clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-005 wb_rst_i  input  1: asynchronous, active-high reset.
REQ-006 configuration  input  4: bit 2 = 1 selects arbitrated mode; bit 2 = 0 selects static mode; bit 0 = static owner.
REQ-007 req_0, req_1  input  1 each: macro 0 / macro 1 request ownership of the north line.
REQ-008 north_o_0, north_o_1, north_oe_0, north_oe_1  input  W each: macro outputs and output enables.
REQ-009 north_o_selected, north_oe_selected  output  W each: drive to the north pads.
REQ-010 gnt_0, gnt_1  output  1 each: ownership grant.
REQ-011 busy  output  1: FSM is not in IDLE.
REQ-012 timeout  output  1: one-cycle pulse on forced release.

Function
REQ-013 FSM states: IDLE, OWN0, OWN1, TURN; the state is registered.
REQ-014 IDLE: a single active request moves the FSM to the corresponding OWNx on the next edge.
REQ-015 IDLE with both requests active: grant goes to the requester that is not last_owner (round-robin).
REQ-016 OWNx: stay while req_x = 1; go to TURN on the edge after req_x samples 0; last_owner <= x.
REQ-017 TURN: lasts exactly TURN_CYCLES cycles.
REQ-018 TURN exit: go to OWNy if the other requester is active, else to OWNx if req_x is active, else IDLE; round-robin rule applies.
REQ-019 gnt_x = 1 only in OWNx; grants are mutually exclusive in every cycle.
REQ-020 The output mux is combinational from the registered state.
REQ-021 In OWNx: north_o_selected = north_o_x and north_oe_selected = north_oe_x, with zero-cycle input-to-output latency.
REQ-022 In IDLE and TURN: north_o_selected = 0 and north_oe_selected = 0.
REQ-023 Request-to-grant latency from IDLE: 1 cycle.
REQ-024 Static mode (configuration[2] = 0): the FSM is forced to IDLE on the next edge and held there.
REQ-025 Static mode outputs: mux select = configuration[0]; gnt_0 = ~configuration[0]; gnt_1 = configuration[0]; busy = 0; requests are ignored.
REQ-026 Static-to-arbitrated transition: the FSM starts in IDLE with last_owner unchanged.
REQ-027 A request deasserted and reasserted within TURN is treated as a new request at TURN exit.

Reset
REQ-028 During reset: state = IDLE, last_owner = 1, tenure counter = 0, TURN counter = 0.
REQ-029 During reset: gnt_0 = gnt_1 = busy = timeout = 0, and both selected buses = 0 irrespective of mode.
REQ-030 Reset asserted mid-tenure or mid-TURN aborts immediately and asynchronously.

Configuration
REQ-031 Macro NORTH_LINE_TIMEOUT_EN defined: a tenure counter increments in each OWNx cycle and clears on entry to OWNx.
REQ-032 With NORTH_LINE_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES and the other request is active: the FSM goes to TURN, last_owner <= x, and timeout pulses for 1 cycle.
REQ-033 With NORTH_LINE_TIMEOUT_EN and no contention: the counter saturates at TIMEOUT_CYCLES and no release occurs.
REQ-034 Macro NORTH_LINE_TIMEOUT_EN undefined: no counter logic exists, the timeout port exists and is tied to 0, and tenure is unbounded.

Structure
REQ-035 Package north_line_pkg holds the FSM state enum, the default W, TURN_CYCLES and TIMEOUT_CYCLES constants, and the configuration bit-index constants.
REQ-036 One sub-module, north_line_tenure_cnt, holds the saturating counter with clear and reached outputs; it is instantiated for TURN always and for tenure only under NORTH_LINE_TIMEOUT_EN.

Verification
REQ-037 Reset release, config = 4'b0100, req_0 = 1 at cycle 3 -> gnt_0 = 1 at cycle 4; north_o_selected = north_o_0 (e.g. 10'h155).
REQ-038 Both requests active from IDLE after reset -> OWN0 first; req_0 drops -> 2 cycles with both selected buses = 0; then OWN1 with north_oe_selected = north_oe_1.
REQ-039 Static mode: config = 4'b0001 with req_0 = 1 -> gnt_1 = 1, busy = 0, north_o_selected = north_o_1; config = 4'b0000 -> selects macro 0 with no gap.
REQ-040 With NORTH_LINE_TIMEOUT_EN, TIMEOUT_CYCLES = 8, req_0 held high, req_1 raised -> timeout pulse on tenure cycle 8, TURN, then gnt_1 = 1.
REQ-041 wb_rst_i asserted for 1 cycle during OWN1 -> gnt_1 and north_oe_selected fall to 0 asynchronously; the next contention grants macro 0.
REQ-042 Randomized requests over 10k cycles -> gnt_0 & gnt_1 never both 1, and oe_selected = 0 in every IDLE and TURN cycle.

Source files
------------

// File: rtl/north_line_pkg.sv
// north_line_pkg: shared types and constants for the north pad line arbiter.
// It holds the FSM state encoding, the default parameter values, the
// configuration bit positions, and the round-robin owner selection rule.
package north_line_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam int DEFAULT_W              = 10;
  localparam int DEFAULT_TURN_CYCLES    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // configuration[CFG_ARB_BIT] = 1 selects arbitrated mode.
  // configuration[CFG_OWNER_BIT] selects the static owner.
  localparam int CFG_ARB_BIT   = 2;
  localparam int CFG_OWNER_BIT = 0;

  // Owner choice from IDLE or at TURN exit. A lone requester wins. When both
  // request, the one that did not own the line last wins.
  function automatic state_t pick_owner(input logic req_0, input logic req_1,
                                        input logic last_owner);
    if (req_0 && req_1) return last_owner ? OWN0 : OWN1;
    else if (req_0)     return OWN0;
    else if (req_1)     return OWN1;
    else                return IDLE;
  endfunction

endpackage

// File: rtl/north_line_tenure_cnt.sv
// north_line_tenure_cnt: saturating up-counter with a synchronous clear.
// The reached output goes high in the cycle whose increment brings the count
// to MAX. It stays high while the count sits at MAX. This lets the owner of
// the count act in that same cycle, so a span of exactly MAX cycles ends
// on time.
module north_line_tenure_cnt
  import north_line_pkg::*;
#(
  parameter int MAX   = 2,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic reached
);

  localparam logic [WIDTH-1:0] LIMIT    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LIMIT_M1 = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count;

  // Count held cycles; clear wins over increment; hold at MAX.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order in which the blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (clear)                 count <= '0;
    else if (inc && count != LIMIT) count <= count + WIDTH'(1);
  end

  assign reached = (count == LIMIT) || (inc && count == LIMIT_M1);

endmodule

// File: rtl/north_line_arbiter.sv
// north_line_arbiter: shares one north pad line between two macros.
// In arbitrated mode, a round-robin FSM runs through IDLE, OWN0, OWN1 and TURN.
// TURN leaves the line idle for TURN_CYCLES cycles between owners.
// In static mode, configuration[0] picks the owner directly.
// Optional build macro NORTH_LINE_TIMEOUT_EN forces an owner to release the
// line after TIMEOUT_CYCLES cycles of tenure while the other macro requests.
// In that case, timeout pulses for one cycle. Without the macro, tenure is
// unbounded and timeout stays 0.
module north_line_arbiter
  import north_line_pkg::*;
#(
  parameter int W              = DEFAULT_W,
  parameter int TURN_CYCLES    = DEFAULT_TURN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [3:0]   configuration,
  input  logic         req_0,
  input  logic         req_1,
  input  logic [W-1:0] north_o_0,
  input  logic [W-1:0] north_o_1,
  input  logic [W-1:0] north_oe_0,
  input  logic [W-1:0] north_oe_1,
  output logic [W-1:0] north_o_selected,
  output logic [W-1:0] north_oe_selected,
  output logic         gnt_0,
  output logic         gnt_1,
  output logic         busy,
  output logic         timeout
);

  state_t state, state_next;
  logic   last_owner, last_owner_next;
  logic   arb_mode, static_sel;
  logic   turn_done, force_release;

  assign arb_mode   = configuration[CFG_ARB_BIT];
  assign static_sel = configuration[CFG_OWNER_BIT];

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{configuration[3], configuration[1]};

  north_line_tenure_cnt #(.MAX(TURN_CYCLES)) u_turn_cnt (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (state != TURN),
    .inc     (state == TURN),
    .reached (turn_done)
  );

`ifdef NORTH_LINE_TIMEOUT_EN
  logic in_own, tenure_done;
  assign in_own = (state == OWN0) || (state == OWN1);

  north_line_tenure_cnt #(.MAX(TIMEOUT_CYCLES)) u_tenure_cnt (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (!in_own),
    .inc     (in_own),
    .reached (tenure_done)
  );

  // Contention exists only while the owner still holds its request and
  // the other macro also requests.
  assign force_release = arb_mode && in_own && tenure_done && req_0 && req_1;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign force_release      = 1'b0;
`endif

  // State and round-robin history registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
    end
  end

  // Next-state logic. Static mode parks the FSM in IDLE and leaves the
  // round-robin history alone.
  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    if (!arb_mode) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = pick_owner(req_0, req_1, last_owner);
        OWN0: if (!req_0 || force_release) begin
          state_next      = TURN;
          last_owner_next = 1'b0;
        end
        OWN1: if (!req_1 || force_release) begin
          state_next      = TURN;
          last_owner_next = 1'b1;
        end
        TURN: if (turn_done) state_next = pick_owner(req_0, req_1, last_owner);
        default: state_next = IDLE;
      endcase
    end
  end

  // Grants, status and the pad mux. Reset forces every output to 0, even
  // in static mode.
  always_comb begin
    gnt_0             = 1'b0;
    gnt_1             = 1'b0;
    busy              = 1'b0;
    timeout           = 1'b0;
    north_o_selected  = '0;
    north_oe_selected = '0;
    if (!wb_rst_i) begin
      if (!arb_mode) begin
        gnt_0             = !static_sel;
        gnt_1             = static_sel;
        north_o_selected  = static_sel ? north_o_1  : north_o_0;
        north_oe_selected = static_sel ? north_oe_1 : north_oe_0;
      end else begin
        busy    = (state != IDLE);
        timeout = force_release;
        case (state)
          OWN0: begin
            gnt_0             = 1'b1;
            north_o_selected  = north_o_0;
            north_oe_selected = north_oe_0;
          end
          OWN1: begin
            gnt_1             = 1'b1;
            north_o_selected  = north_o_1;
            north_oe_selected = north_oe_1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_north_line_arbiter.sv
// tb_north_line_arbiter: self-checking bench for north_line_arbiter.
// The bench has three parts. A directed vector table covers arbitration,
// turnaround, round robin and static mode. Hand-written sequences cover
// reset, async abort and the optional timeout. Last, randomized traffic is
// compared against a cycle-level ownership model.
module tb_north_line_arbiter;

  localparam int W              = 10;
  localparam int TURN_CYCLES    = 2;
  localparam int TIMEOUT_CYCLES = 8;
`ifdef NORTH_LINE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cfg;
  logic         r0, r1;
  logic [W-1:0] o0, o1, oe0, oe1, o_sel, oe_sel;
  logic         g0, g1, busy, tmo;

  always #5 clk = ~clk;

  north_line_arbiter #(
    .W(W), .TURN_CYCLES(TURN_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .configuration     (cfg),
    .req_0             (r0),
    .req_1             (r1),
    .north_o_0         (o0),
    .north_o_1         (o1),
    .north_oe_0        (oe0),
    .north_oe_1        (oe1),
    .north_o_selected  (o_sel),
    .north_oe_selected (oe_sel),
    .gnt_0             (g0),
    .gnt_1             (g1),
    .busy              (busy),
    .timeout           (tmo)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ownership model: owner -1/0/1; gap = idle cycles left before the next owner;
  // tenure = completed cycles of the current ownership.
  int m_owner, m_gap, m_tenure;
  bit m_last;

  task automatic model_reset();
    m_owner  = -1;
    m_gap    = 0;
    m_tenure = 0;
    m_last   = 1'b1;
  endtask

  function automatic int pick(input bit a, input bit b, input bit last);
    if (a && b) return last ? 0 : 1;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_step();
    bit mine, too_long;
    if (!cfg[2]) begin
      m_owner = -1;
      m_gap   = 0;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        m_owner  = pick(r0, r1, m_last);
        m_tenure = 0;
      end
    end else if (m_owner < 0) begin
      m_owner  = pick(r0, r1, m_last);
      m_tenure = 0;
    end else begin
      mine     = (m_owner == 0) ? r0 : r1;
      too_long = TO_EN && r0 && r1 && (m_tenure + 1 >= TIMEOUT_CYCLES);
      m_tenure++;
      if (!mine || too_long) begin
        m_last  = (m_owner == 1);
        m_owner = -1;
        m_gap   = TURN_CYCLES;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] e_o, e_oe;
    logic         e_g0, e_g1, e_busy, e_tmo;
    e_o = '0; e_oe = '0; e_g0 = 0; e_g1 = 0; e_busy = 0; e_tmo = 0;
    if (!rst) begin
      if (!cfg[2]) begin
        e_g0 = !cfg[0];
        e_g1 = cfg[0];
        e_o  = cfg[0] ? o1  : o0;
        e_oe = cfg[0] ? oe1 : oe0;
      end else begin
        e_g0   = (m_owner == 0);
        e_g1   = (m_owner == 1);
        e_busy = (m_owner >= 0) || (m_gap > 0);
        e_o    = (m_owner == 0) ? o0  : (m_owner == 1) ? o1  : '0;
        e_oe   = (m_owner == 0) ? oe0 : (m_owner == 1) ? oe1 : '0;
        e_tmo  = TO_EN && (m_owner >= 0) && r0 && r1 && (m_tenure + 1 >= TIMEOUT_CYCLES);
      end
    end
    check(tag, {g0, g1, busy, tmo, o_sel, oe_sel}, {e_g0, e_g1, e_busy, e_tmo, e_o, e_oe});
    check({tag, "_mutex"}, g0 & g1, 1'b0);
    if (cfg[2] && m_owner < 0) check({tag, "_oe_idle"}, oe_sel, '0);
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic apply(input logic [3:0] c, input logic a, input logic b);
    cfg = c; r0 = a; r1 = b;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fixed_buses();
    o0 = 10'h155; oe0 = 10'h0F0; o1 = 10'h2AA; oe1 = 10'h3C3;
  endtask

  // Directed vectors: sel 0 = bus idle, 1 = macro 0, 2 = macro 1.
  typedef struct {
    logic [3:0] cfg;
    logic       r0, r1;
    logic       g0, g1, busy;
    int         sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] c, input logic a, input logic b,
                     input logic eg0, input logic eg1, input logic eb, input int es);
    vec_t v;
    v.cfg = c; v.r0 = a; v.r1 = b; v.g0 = eg0; v.g1 = eg1; v.busy = eb; v.sel = es;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; cfg = 4'b0001; r0 = 0; r1 = 0;
    fixed_buses();
    model_reset();

    // Reset holds every output low, static mode included.
    repeat (2) @(posedge clk);
    #1;
    check("reset_static", {g0, g1, busy, tmo, o_sel, oe_sel}, '0);
    cfg = 4'b0100;
    #1;
    check("reset_arb", {g0, g1, busy, tmo, o_sel, oe_sel}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // cfg   r0 r1   g0 g1 busy sel
    add(4'b0100, 0, 0, 0, 0, 0, 0);  // IDLE
    add(4'b0100, 1, 1, 0, 0, 0, 0);  // IDLE, both request
    add(4'b0100, 1, 1, 1, 0, 1, 1);  // OWN0 (last_owner starts at 1)
    add(4'b0100, 0, 1, 1, 0, 1, 1);  // still OWN0 while req_0 drops
    add(4'b0100, 0, 1, 0, 0, 1, 0);  // TURN 1
    add(4'b0100, 0, 1, 0, 0, 1, 0);  // TURN 2
    add(4'b0100, 0, 1, 0, 1, 1, 2);  // OWN1
    add(4'b0100, 0, 0, 0, 1, 1, 2);  // OWN1, req_1 drops
    add(4'b0100, 0, 1, 0, 0, 1, 0);  // TURN
    add(4'b0100, 0, 1, 0, 0, 1, 0);  // TURN; only macro 1 asks
    add(4'b0100, 0, 0, 0, 1, 1, 2);  // OWN1 again
    add(4'b0100, 1, 0, 0, 0, 1, 0);  // TURN, req_0 pulses
    add(4'b0100, 0, 0, 0, 0, 1, 0);  // TURN, req_0 gone at exit
    add(4'b0100, 1, 0, 0, 0, 0, 0);  // IDLE
    add(4'b0100, 1, 0, 1, 0, 1, 1);  // OWN0
    add(4'b0001, 1, 0, 0, 1, 0, 2);  // static owner 1, immediate
    add(4'b0001, 1, 0, 0, 1, 0, 2);
    add(4'b0000, 1, 0, 1, 0, 0, 1);  // static owner 0, no gap
    add(4'b0100, 1, 1, 0, 0, 0, 0);  // back to arbitration in IDLE
    add(4'b0100, 1, 1, 1, 0, 1, 1);  // OWN0: last_owner kept at 1
    add(4'b0100, 0, 1, 1, 0, 1, 1);
    add(4'b0100, 0, 1, 0, 0, 1, 0);
    add(4'b0100, 1, 1, 0, 0, 1, 0);  // TURN exit with both -> macro 1
    add(4'b0100, 1, 1, 0, 1, 1, 2);
    add(4'b0100, 0, 0, 0, 1, 1, 2);
    add(4'b0100, 0, 0, 0, 0, 1, 0);
    add(4'b0100, 0, 0, 0, 0, 1, 0);
    add(4'b0100, 0, 0, 0, 0, 0, 0);  // IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      logic [W-1:0] eo, eoe;
      o0 = W'($urandom); oe0 = W'($urandom); o1 = W'($urandom); oe1 = W'($urandom);
      apply(vecs[i].cfg, vecs[i].r0, vecs[i].r1);
      eo  = (vecs[i].sel == 1) ? o0  : (vecs[i].sel == 2) ? o1  : '0;
      eoe = (vecs[i].sel == 1) ? oe0 : (vecs[i].sel == 2) ? oe1 : '0;
      check($sformatf("vec%0d", i), {g0, g1, busy, tmo, o_sel, oe_sel},
            {vecs[i].g0, vecs[i].g1, vecs[i].busy, 1'b0, eo, eoe});
      tick();
    end

    // Request at cycle 3 after reset release; grant one cycle later.
    fixed_buses();
    cfg = 4'b0100; r0 = 0; r1 = 0;
    do_reset();
    apply(4'b0100, 0, 0); tick();
    apply(4'b0100, 0, 0); tick();
    apply(4'b0100, 1, 0); check("lat_cycle3_gnt0", g0, 1'b0); tick();
    apply(4'b0100, 1, 0); check("lat_cycle4_gnt0", g0, 1'b1);
    check("lat_cycle4_o_sel", o_sel, 10'h155);
    tick();
    // Hand over to macro 1, then abort its tenure with an async reset.
    apply(4'b0100, 0, 1); tick();
    apply(4'b0100, 0, 1); tick();
    apply(4'b0100, 0, 1); tick();
    apply(4'b0100, 0, 1); check("own1_gnt1", g1, 1'b1);
    check("own1_oe_sel", oe_sel, 10'h3C3);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_gnt1", g1, 1'b0);
    check("async_rst_oe_sel", oe_sel, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(4'b0100, 1, 1); check("post_rst_idle", {g0, g1, busy}, 3'b000); tick();
    apply(4'b0100, 1, 1); check("post_rst_gnt0", {g0, g1}, 2'b10); tick();

`ifdef NORTH_LINE_TIMEOUT_EN
    // Macro 0 holds on; macro 1 joins at tenure cycle 3; release at tenure cycle 8.
    do_reset();
    apply(4'b0100, 1, 0); tick();
    for (int k = 1; k <= 8; k++) begin
      apply(4'b0100, 1'b1, k >= 3);
      check($sformatf("to_gnt0_t%0d", k), g0, 1'b1);
      check($sformatf("to_pulse_t%0d", k), tmo, k == 8);
      tick();
    end
    for (int k = 0; k < TURN_CYCLES; k++) begin
      apply(4'b0100, 1, 1);
      check($sformatf("to_turn%0d", k), {g0, g1, busy, tmo}, 4'b0010);
      tick();
    end
    apply(4'b0100, 1, 1); check("to_gnt1", {g0, g1}, 2'b01); tick();
`endif

    // Randomized traffic against the ownership model.
    cfg = 4'b0100; r0 = 0; r1 = 0;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      if ($urandom_range(0, 99) == 0) cfg[2] = ~cfg[2];
      cfg[3] = 1'($urandom);
      cfg[1] = 1'($urandom);
      if (!cfg[2] && $urandom_range(0, 7) == 0) cfg[0] = ~cfg[0];
      o0 = W'($urandom); oe0 = W'($urandom); o1 = W'($urandom); oe1 = W'($urandom);
      #1;
      check_model($sformatf("rand%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
